// File: rtl/swt16_mem_pkg.sv
// Shared types and helpers for the swt16 MEM/LSU stage.
package swt16_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } lsu_state_t;

  localparam logic SIZE_BYTE = 1'b1;
  localparam logic SIZE_WORD = 1'b0;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering: store-side byte replication/enables and load-side lane select with extension.
module mem_lane_align
  import swt16_mem_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned RES_WIDTH  = 16,
  parameter int unsigned BYTES      = WORD_WIDTH / 8,
  parameter int unsigned LANE_BITS  = clog2(WORD_WIDTH / 8)
) (
  input  logic                  size_byte,
  input  logic                  load_signed,
  input  logic [LANE_BITS-1:0]  lane,
  input  logic [WORD_WIDTH-1:0] wr_word,
  input  logic [WORD_WIDTH-1:0] rd_word,
  output logic [WORD_WIDTH-1:0] st_word,
  output logic [BYTES-1:0]      byte_en,
  output logic [RES_WIDTH-1:0]  ld_res
);

  logic [7:0]           sel_byte;
  logic [RES_WIDTH-1:0] ext_byte;
  logic [RES_WIDTH-1:0] ext_word;

  always_comb begin
    sel_byte = rd_word[{lane, 3'b000} +: 8];
    ext_byte = {RES_WIDTH{load_signed & sel_byte[7]}};
    ext_byte[7:0] = sel_byte;
    ext_word = {RES_WIDTH{load_signed & rd_word[WORD_WIDTH-1]}};
    ext_word[WORD_WIDTH-1:0] = rd_word;

    if (size_byte == SIZE_BYTE) begin
      st_word = {BYTES{wr_word[7:0]}};
      byte_en = {{(BYTES-1){1'b0}}, 1'b1} << lane;
      ld_res  = ext_byte;
    end else begin
      st_word = wr_word;
      byte_en = {BYTES{1'b1}};
      ld_res  = ext_word;
    end
  end

endmodule

// File: rtl/mem_lsu.sv
// swt16 MEM stage: pass-through for ALU results, req/ack DMEM access with stall,
// sub-word lanes, misalignment and bus-timeout reporting.
module mem_lsu
  import swt16_mem_pkg::*;
#(
  parameter int unsigned DMEM_ADDR_WIDTH = 12,
  parameter int unsigned DMEM_WORD_WIDTH = 16,
  parameter int unsigned IALU_WORD_WIDTH = 16,
  parameter int unsigned REG_IDX_WIDTH   = 4,
  parameter int unsigned TIMEOUT_WIDTH   = 8,
  parameter int unsigned BYTES           = DMEM_WORD_WIDTH / 8,
  parameter int unsigned LANE_BITS       = clog2(DMEM_WORD_WIDTH / 8)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic                                 in_act_load,
  input  logic                                 in_act_store,
  input  logic                                 in_act_write_res_to_reg,
  input  logic                                 in_size_byte,
  input  logic                                 in_load_signed,
  input  logic [DMEM_ADDR_WIDTH+LANE_BITS-1:0] in_addr,
  input  logic [DMEM_WORD_WIDTH-1:0]           in_wr_word,
  input  logic [IALU_WORD_WIDTH-1:0]           in_res,
  input  logic [REG_IDX_WIDTH-1:0]             in_res_reg_idx,
  output logic                                 out_stall,
  output logic                                 out_dmem_req,
  output logic                                 out_dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0]           out_dmem_addr,
  output logic [DMEM_WORD_WIDTH-1:0]           out_dmem_wr_word,
  output logic [BYTES-1:0]                     out_dmem_byte_en,
  input  logic                                 in_dmem_ack,
  input  logic [DMEM_WORD_WIDTH-1:0]           in_dmem_rd_word,
  output logic                                 out_valid,
  output logic                                 out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0]           out_res,
  output logic [REG_IDX_WIDTH-1:0]             out_res_reg_idx,
  output logic                                 out_misaligned,
  output logic                                 out_bus_error
);

  lsu_state_t                 state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LANE_BITS-1:0]       lane_q, lane_d;
  logic                       byte_q, byte_d;
  logic                       sgn_q, sgn_d;
  logic                       we_q, we_d;
  logic [DMEM_WORD_WIDTH-1:0] wr_q, wr_d;
  logic [REG_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                       wb_q, wb_d;

  logic                       valid_q, valid_d;
  logic                       wb_out_q, wb_out_d;
  logic [IALU_WORD_WIDTH-1:0] res_q, res_d;
  logic [REG_IDX_WIDTH-1:0]   idx_out_q, idx_out_d;
  logic                       mis_q, mis_d;
  logic                       berr_q, berr_d;

  logic                       is_mem;
  logic                       misaligned;
  logic                       req;
  logic [DMEM_WORD_WIDTH-1:0] st_word;
  logic [BYTES-1:0]           byte_en;
  logic [IALU_WORD_WIDTH-1:0] ld_res;

  mem_lane_align #(
    .WORD_WIDTH(DMEM_WORD_WIDTH),
    .RES_WIDTH (IALU_WORD_WIDTH),
    .BYTES     (BYTES),
    .LANE_BITS (LANE_BITS)
  ) u_align (
    .size_byte  (byte_q),
    .load_signed(sgn_q),
    .lane       (lane_q),
    .wr_word    (wr_q),
    .rd_word    (in_dmem_rd_word),
    .st_word    (st_word),
    .byte_en    (byte_en),
    .ld_res     (ld_res)
  );

  assign is_mem     = in_act_load | in_act_store;
  assign misaligned = (in_size_byte == SIZE_WORD) && (in_addr[LANE_BITS-1:0] != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    lane_d    = lane_q;
    byte_d    = byte_q;
    sgn_d     = sgn_q;
    we_d      = we_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wb_d      = wb_q;
    valid_d   = 1'b0;
    wb_out_d  = 1'b0;
    res_d     = '0;
    idx_out_d = '0;
    mis_d     = 1'b0;
    berr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            valid_d   = 1'b1;
            wb_out_d  = in_act_write_res_to_reg;
            res_d     = in_res;
            idx_out_d = in_res_reg_idx;
          end else if (misaligned) begin
            valid_d   = 1'b1;
            mis_d     = 1'b1;
            idx_out_d = in_res_reg_idx;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
            addr_d  = in_addr[DMEM_ADDR_WIDTH+LANE_BITS-1:LANE_BITS];
            lane_d  = in_addr[LANE_BITS-1:0];
            byte_d  = in_size_byte;
            sgn_d   = in_load_signed;
            we_d    = in_act_store;  // load+store together behaves as a store
            wr_d    = in_wr_word;
            idx_d   = in_res_reg_idx;
            wb_d    = in_act_write_res_to_reg;
          end
        end
      end
      ACCESS: begin
        if (in_dmem_ack) begin
          state_d   = IDLE;
          valid_d   = 1'b1;
          idx_out_d = idx_q;
          if (!we_q) begin
            wb_out_d = wb_q;
            res_d    = ld_res;
          end
        end else if (cnt_q == {TIMEOUT_WIDTH{1'b1}}) begin
          state_d   = IDLE;
          valid_d   = 1'b1;
          berr_d    = 1'b1;
          idx_out_d = idx_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lane_q    <= '0;
      byte_q    <= 1'b0;
      sgn_q     <= 1'b0;
      we_q      <= 1'b0;
      wr_q      <= '0;
      idx_q     <= '0;
      wb_q      <= 1'b0;
      valid_q   <= 1'b0;
      wb_out_q  <= 1'b0;
      res_q     <= '0;
      idx_out_q <= '0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      lane_q    <= lane_d;
      byte_q    <= byte_d;
      sgn_q     <= sgn_d;
      we_q      <= we_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      wb_q      <= wb_d;
      valid_q   <= valid_d;
      wb_out_q  <= wb_out_d;
      res_q     <= res_d;
      idx_out_q <= idx_out_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  // Bus-side outputs follow the state register directly, so reset drops them at once.
  assign req              = (state_q == ACCESS);
  assign out_stall        = req;
  assign out_dmem_req     = req;
  assign out_dmem_we      = req & we_q;
  assign out_dmem_addr    = req ? addr_q : '0;
  assign out_dmem_wr_word = req ? st_word : '0;
  assign out_dmem_byte_en = req ? byte_en : '0;

  assign out_valid                = valid_q;
  assign out_act_write_res_to_reg = wb_out_q;
  assign out_res                  = res_q;
  assign out_res_reg_idx          = idx_out_q;
  assign out_misaligned           = mis_q;
  assign out_bus_error            = berr_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, reset corner cases and
// randomized ops checked against a word-array memory model.
module tb_mem_lsu;

  localparam int TW = 3;
  localparam int TO = 1 << TW;  // ACCESS cycles before a timeout fires

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_act_load, in_act_store, in_act_write_res_to_reg;
  logic        in_size_byte, in_load_signed;
  logic [12:0] in_addr;
  logic [15:0] in_wr_word, in_res;
  logic [3:0]  in_res_reg_idx;
  logic        out_stall, out_dmem_req, out_dmem_we;
  logic [11:0] out_dmem_addr;
  logic [15:0] out_dmem_wr_word;
  logic [1:0]  out_dmem_byte_en;
  logic        in_dmem_ack;
  logic [15:0] in_dmem_rd_word;
  logic        out_valid, out_act_write_res_to_reg;
  logic [15:0] out_res;
  logic [3:0]  out_res_reg_idx;
  logic        out_misaligned, out_bus_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit ld, st, byt, sgn;
    bit [12:0] addr;
    bit [15:0] wr, res;
    bit [3:0]  idx;
    bit        wb;
    int        delay;
    bit [15:0] rd;
    bit        exp_mis, exp_err;
    bit [15:0] exp_res;
    bit        exp_wb;
    bit [11:0] exp_waddr;
    bit [1:0]  exp_be;
    bit [15:0] exp_wdata;
    bit        exp_we;
  } vec_t;

  vec_t       tbl[12];
  logic [15:0] mem[4096];

  mem_lsu #(.TIMEOUT_WIDTH(TW)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .in_valid                (in_valid),
    .in_act_load             (in_act_load),
    .in_act_store            (in_act_store),
    .in_act_write_res_to_reg (in_act_write_res_to_reg),
    .in_size_byte            (in_size_byte),
    .in_load_signed          (in_load_signed),
    .in_addr                 (in_addr),
    .in_wr_word              (in_wr_word),
    .in_res                  (in_res),
    .in_res_reg_idx          (in_res_reg_idx),
    .out_stall               (out_stall),
    .out_dmem_req            (out_dmem_req),
    .out_dmem_we             (out_dmem_we),
    .out_dmem_addr           (out_dmem_addr),
    .out_dmem_wr_word        (out_dmem_wr_word),
    .out_dmem_byte_en        (out_dmem_byte_en),
    .in_dmem_ack             (in_dmem_ack),
    .in_dmem_rd_word         (in_dmem_rd_word),
    .out_valid               (out_valid),
    .out_act_write_res_to_reg(out_act_write_res_to_reg),
    .out_res                 (out_res),
    .out_res_reg_idx         (out_res_reg_idx),
    .out_misaligned          (out_misaligned),
    .out_bus_error           (out_bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_act_load = 0; in_act_store = 0; in_act_write_res_to_reg = 0;
    in_size_byte = 0; in_load_signed = 0; in_addr = '0; in_wr_word = '0;
    in_res = '0; in_res_reg_idx = '0; in_dmem_ack = 0; in_dmem_rd_word = '0;
  endtask

  task automatic scramble_inputs();
    in_valid = 1'($urandom); in_act_load = 1'($urandom); in_act_store = 1'($urandom);
    in_act_write_res_to_reg = 1'($urandom); in_size_byte = 1'($urandom);
    in_load_signed = 1'($urandom); in_addr = 13'($urandom); in_wr_word = 16'($urandom);
    in_res = 16'($urandom); in_res_reg_idx = 4'($urandom);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns at the same phase, idle again.
  task automatic run_op(input vec_t v);
    bit mem_op;
    bit acked;
    mem_op = (v.ld || v.st) && !v.exp_mis;
    chk("idle_stall", out_stall, 0);
    chk("idle_req", out_dmem_req, 0);
    in_valid = 1; in_act_load = v.ld; in_act_store = v.st; in_act_write_res_to_reg = v.wb;
    in_size_byte = v.byt; in_load_signed = v.sgn; in_addr = v.addr; in_wr_word = v.wr;
    in_res = v.res; in_res_reg_idx = v.idx;
    @(posedge clock); #1;
    acked = 0;
    if (mem_op) begin
      for (int k = 0; k < TO; k++) begin
        chk("acc_stall", out_stall, 1);
        chk("acc_req", out_dmem_req, 1);
        chk("acc_valid", out_valid, 0);
        chk("acc_addr", out_dmem_addr, v.exp_waddr);
        chk("acc_be", out_dmem_byte_en, v.exp_be);
        chk("acc_we", out_dmem_we, v.exp_we);
        if (v.exp_we) chk("acc_wdata", out_dmem_wr_word, v.exp_wdata);
        scramble_inputs();
        in_dmem_ack = (k == v.delay);
        in_dmem_rd_word = (k == v.delay) ? v.rd : 16'($urandom);
        @(posedge clock); #1;
        in_dmem_ack = 0;
        if (k == v.delay) begin
          acked = 1;
          break;
        end
      end
    end else begin
      idle_inputs();
    end
    idle_inputs();
    in_dmem_ack = 1'($urandom);  // must be ignored in IDLE
    chk("res_valid", out_valid, 1);
    chk("res_mis", out_misaligned, v.exp_mis);
    chk("res_berr", out_bus_error, v.exp_err);
    chk("res_stall", out_stall, 0);
    chk("res_req", out_dmem_req, 0);
    chk("res_data", out_res, v.exp_res);
    chk("res_wb", out_act_write_res_to_reg, v.exp_wb);
    if (!v.exp_mis && !v.exp_err) chk("res_idx", out_res_reg_idx, v.idx);
    if (mem_op && !v.exp_err) chk("res_acked", acked, 1);
    @(posedge clock); #1;
    in_dmem_ack = 0;
    chk("pulse_valid", out_valid, 0);
    chk("pulse_mis", out_misaligned, 0);
    chk("pulse_berr", out_bus_error, 0);
    chk("post_req", out_dmem_req, 0);
  endtask

  // Reference model: expected response and memory side effects straight from the op rules.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit [7:0] b;
    bit [15:0] w;
    bit lane;
    r = v;
    lane = v.addr[0];
    r.exp_waddr = v.addr[12:1];
    r.exp_be    = v.byt ? 2'(1 << lane) : 2'b11;
    r.exp_wdata = v.byt ? {v.wr[7:0], v.wr[7:0]} : v.wr;
    r.exp_we    = v.st;
    r.exp_mis   = (v.ld || v.st) && !v.byt && lane;
    r.exp_err   = (v.ld || v.st) && !r.exp_mis && (v.delay >= TO);
    r.exp_res   = '0;
    r.exp_wb    = 0;
    r.rd        = mem[r.exp_waddr];
    if (!v.ld && !v.st) begin
      r.exp_res = v.res;
      r.exp_wb  = v.wb;
    end else if (!r.exp_mis && !r.exp_err && !v.st) begin
      w = r.rd;
      b = lane ? w[15:8] : w[7:0];
      if (v.byt) r.exp_res = v.sgn ? 16'($signed(b)) : 16'(b);
      else       r.exp_res = w;
      r.exp_wb = v.wb;
    end
    return r;
  endfunction

  task automatic mem_write(input vec_t r);
    if (r.exp_we && !r.exp_mis && !r.exp_err) begin
      if (r.exp_be[0]) mem[r.exp_waddr][7:0]  = r.exp_wdata[7:0];
      if (r.exp_be[1]) mem[r.exp_waddr][15:8] = r.exp_wdata[15:8];
    end
  endtask

  initial begin
    vec_t v;
    // ld st byt sgn addr wr res idx wb delay rd | mis err res wb waddr be wdata we
    tbl[0]  = '{0,0,0,0, 13'h000, 16'h0000, 16'h1234, 4'd3, 1, 0, 16'h0000,
                0,0, 16'h1234, 1, 12'h000, 2'b00, 16'h0000, 0};
    tbl[1]  = '{1,0,0,1, 13'h010, 16'h0000, 16'h0000, 4'd5, 1, 2, 16'h8001,
                0,0, 16'h8001, 1, 12'h008, 2'b11, 16'h0000, 0};
    tbl[2]  = '{1,0,1,1, 13'h011, 16'h0000, 16'h0000, 4'd6, 1, 0, 16'hF07F,
                0,0, 16'hFFF0, 1, 12'h008, 2'b10, 16'h0000, 0};
    tbl[3]  = '{1,0,1,0, 13'h011, 16'h0000, 16'h0000, 4'd7, 1, 1, 16'hF07F,
                0,0, 16'h00F0, 1, 12'h008, 2'b10, 16'h0000, 0};
    tbl[4]  = '{0,1,1,0, 13'h005, 16'h00AB, 16'h5555, 4'd2, 1, 1, 16'h0000,
                0,0, 16'h0000, 0, 12'h002, 2'b10, 16'hABAB, 1};
    tbl[5]  = '{0,1,0,0, 13'h003, 16'h1111, 16'h7777, 4'd1, 1, 0, 16'h0000,
                1,0, 16'h0000, 0, 12'h001, 2'b11, 16'h0000, 0};
    tbl[6]  = '{1,0,0,0, 13'h001, 16'h0000, 16'h7777, 4'd1, 1, 0, 16'h0000,
                1,0, 16'h0000, 0, 12'h000, 2'b11, 16'h0000, 0};
    tbl[7]  = '{1,1,0,0, 13'h020, 16'hBEEF, 16'h0000, 4'd9, 1, 0, 16'h1234,
                0,0, 16'h0000, 0, 12'h010, 2'b11, 16'hBEEF, 1};
    tbl[8]  = '{1,0,0,0, 13'h040, 16'h0000, 16'h0000, 4'd4, 1, 99, 16'h0000,
                0,1, 16'h0000, 0, 12'h020, 2'b11, 16'h0000, 0};
    tbl[9]  = '{1,0,1,1, 13'h012, 16'h0000, 16'h0000, 4'd8, 1, 3, 16'h3480,
                0,0, 16'hFF80, 1, 12'h009, 2'b01, 16'h0000, 0};
    tbl[10] = '{0,0,0,0, 13'h1FF, 16'h0000, 16'hABCD, 4'd15, 0, 0, 16'h0000,
                0,0, 16'hABCD, 0, 12'h000, 2'b00, 16'h0000, 0};
    tbl[11] = '{0,1,0,0, 13'h1FFE, 16'hC3A5, 16'h0000, 4'd0, 0, 7, 16'h0000,
                0,0, 16'h0000, 0, 12'hFFF, 2'b11, 16'hC3A5, 1};

    idle_inputs();
    reset = 1;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_req", out_dmem_req, 0);
    chk("rst_stall", out_stall, 0);
    chk("rst_be", out_dmem_byte_en, 0);
    chk("rst_res", out_res, 0);
    #10 reset = 0;
    @(posedge clock); #1;

    for (int i = 0; i < 12; i++) run_op(tbl[i]);

    // Reset while an access is outstanding: bus drops immediately, nothing completes.
    in_valid = 1; in_act_load = 1; in_addr = 13'h030;
    @(posedge clock); #1;
    idle_inputs();
    chk("mid_req_before", out_dmem_req, 1);
    @(posedge clock); #2;
    reset = 1;
    #1;
    chk("mid_rst_req", out_dmem_req, 0);
    chk("mid_rst_stall", out_stall, 0);
    chk("mid_rst_be", out_dmem_byte_en, 0);
    @(posedge clock); #1;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      in_dmem_ack = 1'($urandom);
      @(posedge clock); #1;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_req", out_dmem_req, 0);
    end
    in_dmem_ack = 0;

    for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      v = tbl[0];
      v.ld  = (kind == 1) || (kind == 3 && $urandom_range(0, 3) == 0);
      v.st  = (kind == 2) || (kind == 3 && !v.ld) || (kind == 3 && v.ld);
      if (kind == 0) begin v.ld = 0; v.st = 0; end
      if (kind == 1) v.st = 0;
      v.byt   = 1'($urandom);
      v.sgn   = 1'($urandom);
      v.addr  = 13'($urandom);
      if (!v.byt && $urandom_range(0, 4) != 0) v.addr[0] = 0;
      v.wr    = 16'($urandom);
      v.res   = 16'($urandom);
      v.idx   = 4'($urandom);
      v.wb    = 1'($urandom);
      v.delay = $urandom_range(0, TO + 1);
      v = model(v);
      run_op(v);
      mem_write(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
